divider_iter_unit: RTL and testbench
====================================

Name: divider_iter_unit

Overview:
- Parametrised, iterative radix-2 restoring divider execution unit. It is the successor to the fixed 32-bit tagged divider.
- Accepts one tagged divide from the issue queue, holds busy while iterating, then returns quotient and remainder (HI/LO) with the tag and a one-cycle valid pulse.
- Adds signed/unsigned mode, a divide-by-zero flag, flush/abort and a configurable width.
- Sits between the divide issue queue and the CDB/writeback arbiter.

Parameters:
- WIDTH, 32: operand, quotient and remainder width; must be ≥4.
- TAG_W, 6: destination tag width.
- CNT_W, 6: iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- issuediv_enable  in  1  issue strobe; accepted only when issuediv_busy=0.
- issuediv_signed  in  1  1 = two's-complement divide (DIV), 0 = unsigned (DIVU).
- issuediv_rsdata  in  WIDTH  dividend.
- issuediv_rtdata  in  WIDTH  divisor.
- issuediv_rdtag  in  TAG_W  destination tag.
- issuediv_flush  in  1  abort any in-flight divide.
- issuediv_busy  out  1  unit occupied; issue queue must not issue.
- issuediv_valid  out  1  one-cycle result-valid pulse.
- issuediv_quot  out  WIDTH  quotient (LO).
- issuediv_rem  out  WIDTH  remainder (HI).
- issuediv_dz  out  1  divisor was zero; qualified by valid.
- issuediv_rdtag_out  out  TAG_W  tag of the result; qualified by valid.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - busy=0, valid=0, dz=0.
  - quot, rem and rdtag_out all 0.
  - counter=0.
- States:
  - IDLE -> CALC on an accepted issue.
  - CALC -> DONE after WIDTH iterations.
  - DONE -> IDLE unconditionally.
- Accept: enable=1 and state=IDLE on a rising edge. The unit latches rsdata, rtdata, rdtag and signed. Enable while busy is ignored and nothing is latched.
- busy = (state != IDLE). It is combinational from state, so it rises in the cycle after accept.
- Operand prep at accept:
  - signed=1: magnitudes |rs| and |rt| are used. Latch qneg = rs[MSB]^rt[MSB] and rneg = rs[MSB].
  - signed=0: operands are used as-is; qneg=rneg=0.
- CALC:
  - One quotient bit per cycle, MSB first, using a (WIDTH+1)-bit partial remainder.
  - Counter counts WIDTH-1 down to 0; the transition to DONE occurs on the edge where counter=0.
- DONE:
  - valid=1 for exactly one cycle.
  - quot = qneg ? −Q : Q and rem = rneg ? −R : R, each truncated to WIDTH.
  - rdtag_out = latched tag.
  - Result registers hold their values after valid drops, until the next DONE.
- Latency: valid asserts WIDTH+1 cycles after the accept edge (33 for WIDTH=32). Throughput is one divide per WIDTH+2 cycles.
- Next accept: the earliest is the cycle after DONE, when busy=0. There is no issue in the DONE cycle.
- Divide by zero (rt==0):
  - quot = all ones, rem = rs raw (sign not applied), dz=1.
  - Latency is unchanged.
- Signed overflow (MIN / −1): quot = MIN, rem = 0, dz=0. No trap.
- Flush:
  - Flush=1 in CALC or DONE -> next state IDLE; valid is forced 0 in that cycle; result registers are unchanged.
  - Flush in IDLE has no effect.
  - Flush and enable together in IDLE: flush wins and nothing is accepted.
- Reset mid-operation: immediate return to IDLE and the full reset values above. No valid pulse is emitted for the aborted divide.

Test Plan:
- Unsigned 100 / 7 (WIDTH=32), issued with tag 0x15 -> valid in cycle 33 after accept; quot=14, rem=2, rdtag_out=0x15, dz=0; busy high for 33 cycles.
- Signed −7 / 2 (0xFFFFFFF9 / 0x00000002) -> quot=0xFFFFFFFD, rem=0xFFFFFFFF. Same operands unsigned -> quot=0x7FFFFFFC, rem=1.
- 0x00001234 / 0 (signed and unsigned) -> quot=0xFFFFFFFF, rem=0x00001234, dz=1. Then signed 0x80000000 / 0xFFFFFFFF -> quot=0x80000000, rem=0, dz=0.
- Issue A, pulse enable every cycle during busy with a different tag -> only A is produced. B is accepted on the first cycle busy=0, and its valid arrives 33 cycles later.
- Flush at iteration 10 -> busy=0 next cycle and no valid pulse. Drive reset low at iteration 20 of a new divide -> all outputs 0 immediately; after release, 50/5 completes with quot=10.
- WIDTH=8, CNT_W=4 instance: 200 / 3 unsigned -> quot=66, rem=2, valid at cycle 9; signed 0x80 / 0xFF -> quot=0x80, rem=0.

Source files
------------

// File: rtl/divider_iter_unit_if.sv
// Issue/result bundle between the divide issue queue, the iterative divider and writeback.
interface divider_iter_unit_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 6
);
  logic             issuediv_enable;
  logic             issuediv_signed;
  logic [WIDTH-1:0] issuediv_rsdata;
  logic [WIDTH-1:0] issuediv_rtdata;
  logic [TAG_W-1:0] issuediv_rdtag;
  logic             issuediv_flush;
  logic             issuediv_busy;
  logic             issuediv_valid;
  logic [WIDTH-1:0] issuediv_quot;
  logic [WIDTH-1:0] issuediv_rem;
  logic             issuediv_dz;
  logic [TAG_W-1:0] issuediv_rdtag_out;

  modport master (
    output issuediv_enable, issuediv_signed, issuediv_rsdata, issuediv_rtdata,
           issuediv_rdtag, issuediv_flush,
    input  issuediv_busy, issuediv_valid, issuediv_quot, issuediv_rem,
           issuediv_dz, issuediv_rdtag_out
  );

  modport slave (
    input  issuediv_enable, issuediv_signed, issuediv_rsdata, issuediv_rtdata,
           issuediv_rdtag, issuediv_flush,
    output issuediv_busy, issuediv_valid, issuediv_quot, issuediv_rem,
           issuediv_dz, issuediv_rdtag_out
  );
endinterface

// File: rtl/divider_iter_unit.sv
// Iterative radix-2 restoring divider: one quotient bit per cycle, signed/unsigned,
// divide-by-zero flag and flush. Results are held until the next completed divide.
module divider_iter_unit #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 6,
  parameter int CNT_W = 6
) (
  input logic               clk,
  input logic               reset,
  divider_iter_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] quot_r, rem_r;
  logic             dz_r;
  logic [TAG_W-1:0] tag_r;

  logic [WIDTH-1:0] divisor, q_work, pr_work, rs_raw;
  logic             qneg, rneg, dz_pend;
  logic [TAG_W-1:0] tag_hold;

  logic             accept;
  logic [WIDTH:0]   shifted;
  logic             ge;
  logic [WIDTH-1:0] pr_next, q_next;

  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v, input logic sgn);
    return (sgn && v < 0) ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  // Flush beats enable in IDLE, so a flushed cycle never starts a divide.
  assign accept = (state == IDLE) && bus.issuediv_enable && !bus.issuediv_flush;

  // Partial remainder is WIDTH+1 bits once the next dividend bit is shifted in;
  // when the trial subtract succeeds the difference always fits back in WIDTH bits.
  assign shifted = {pr_work, q_work[WIDTH-1]};
  assign ge      = shifted >= {1'b0, divisor};
  assign pr_next = ge ? (shifted[WIDTH-1:0] - divisor) : shifted[WIDTH-1:0];
  assign q_next  = {q_work[WIDTH-2:0], ge};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      count  <= '0;
      quot_r <= '0;
      rem_r  <= '0;
      dz_r   <= 1'b0;
      tag_r  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state <= CALC;
            count <= CNT_W'(WIDTH - 1);
          end
        end
        CALC: begin
          if (bus.issuediv_flush) begin
            state <= IDLE;
          end else if (count == '0) begin
            state  <= DONE;
            quot_r <= dz_pend ? '1 : apply_sign(q_next, qneg);
            rem_r  <= dz_pend ? rs_raw : apply_sign(pr_next, rneg);
            dz_r   <= dz_pend;
            tag_r  <= tag_hold;
          end else begin
            count <= count - 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Working operands carry no reset; they are always reloaded on accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      q_work   <= mag(bus.issuediv_rsdata, bus.issuediv_signed);
      divisor  <= mag(bus.issuediv_rtdata, bus.issuediv_signed);
      pr_work  <= '0;
      rs_raw   <= bus.issuediv_rsdata;
      qneg     <= bus.issuediv_signed & (bus.issuediv_rsdata[WIDTH-1] ^ bus.issuediv_rtdata[WIDTH-1]);
      rneg     <= bus.issuediv_signed & bus.issuediv_rsdata[WIDTH-1];
      dz_pend  <= (bus.issuediv_rtdata == '0);
      tag_hold <= bus.issuediv_rdtag;
    end else if (state == CALC) begin
      q_work  <= q_next;
      pr_work <= pr_next;
    end
  end

  assign bus.issuediv_busy      = (state != IDLE);
  assign bus.issuediv_valid     = (state == DONE) && !bus.issuediv_flush;
  assign bus.issuediv_quot      = quot_r;
  assign bus.issuediv_rem       = rem_r;
  assign bus.issuediv_dz        = dz_r;
  assign bus.issuediv_rdtag_out = tag_r;
endmodule

// File: tb/tb_divider_iter_unit.sv
// Randomised and directed bench for divider_iter_unit with a cycle-level behavioural model.
module tb_divider_iter_unit;
  localparam int W  = 32;
  localparam int TW = 6;
  localparam int W8 = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  divider_iter_unit_if #(.WIDTH(W),  .TAG_W(TW)) bus  ();
  divider_iter_unit_if #(.WIDTH(W8), .TAG_W(TW)) bus8 ();

  divider_iter_unit #(.WIDTH(W),  .TAG_W(TW), .CNT_W(6)) dut  (.clk(clk), .reset(rst_n), .bus(bus.slave));
  divider_iter_unit #(.WIDTH(W8), .TAG_W(TW), .CNT_W(4)) dut8 (.clk(clk), .reset(rst_n), .bus(bus8.slave));

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;
  int vcount = 0;
  logic [TW-1:0] vtags[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference divide from plain integer arithmetic (truncating signed division).
  function automatic void ref_div(input int w, input bit sgn, input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] q, output logic [63:0] r, output bit dz);
    longint mask = (longint'(1) << w) - 1;
    longint sa, sb;
    if (b == 0) begin
      q = mask; r = a; dz = 1'b1;
    end else if (!sgn) begin
      q = a / b; r = a % b; dz = 1'b0;
    end else begin
      sa = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
      sb = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
      q = (sa / sb) & mask;
      r = (sa % sb) & mask;
      dz = 1'b0;
    end
  endfunction

  // Cycle model of the 32-bit unit: m_cnt is the number of busy cycles still ahead.
  int            m_cnt = 0;
  logic [W-1:0]  m_quot = '0, m_rem = '0, p_quot = '0, p_rem = '0;
  logic          m_dz = 1'b0, p_dz = 1'b0;
  logic [TW-1:0] m_tag = '0, p_tag = '0;
  logic [63:0]   tq, tr;
  bit            tdz;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= 0; m_quot <= '0; m_rem <= '0; m_dz <= 1'b0; m_tag <= '0;
    end else if (m_cnt == 0) begin
      if (bus.issuediv_enable && !bus.issuediv_flush) begin
        ref_div(W, bus.issuediv_signed, 64'(bus.issuediv_rsdata), 64'(bus.issuediv_rtdata), tq, tr, tdz);
        m_cnt  <= W + 1;
        p_quot <= tq[W-1:0];
        p_rem  <= tr[W-1:0];
        p_dz   <= tdz;
        p_tag  <= bus.issuediv_rdtag;
      end
    end else if (bus.issuediv_flush) begin
      m_cnt <= 0;
    end else begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 2) begin
        m_quot <= p_quot; m_rem <= p_rem; m_dz <= p_dz; m_tag <= p_tag;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("busy",  bus.issuediv_busy,  m_cnt != 0);
      check("valid", bus.issuediv_valid, (m_cnt == 1) && !bus.issuediv_flush);
      check("quot",  bus.issuediv_quot,  m_quot);
      check("rem",   bus.issuediv_rem,   m_rem);
      check("dz",    bus.issuediv_dz,    m_dz);
      check("tag",   bus.issuediv_rdtag_out, m_tag);
      if (bus.issuediv_valid) begin
        vcount++;
        vtags.push_back(bus.issuediv_rdtag_out);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic issue32(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b, input logic [TW-1:0] tag);
    tick();
    bus.issuediv_enable = 1'b1; bus.issuediv_signed = sgn;
    bus.issuediv_rsdata = a; bus.issuediv_rtdata = b; bus.issuediv_rdtag = tag;
    tick();
    bus.issuediv_enable = 1'b0;
  endtask

  // Counts cycles after the accept edge until valid; returns the busy-cycle count too.
  task automatic wait_valid32(input string nm, output int cyc, output int bcyc);
    cyc = 0; bcyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.issuediv_busy) bcyc++;
      if (bus.issuediv_valid) return;
      if (cyc >= 100) begin
        tests++; fails++;
        $display("FAIL %s_timeout: no valid after %0d cycles, required %0d", nm, cyc, W + 1);
        return;
      end
    end
  endtask

  task automatic op32(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b, input logic [TW-1:0] tag,
                      input logic [W-1:0] eq, input logic [W-1:0] er, input bit edz, input string nm);
    int cyc, bcyc;
    issue32(sgn, a, b, tag);
    wait_valid32(nm, cyc, bcyc);
    check({nm, "_lat"},  cyc, W + 1);
    check({nm, "_busy"}, bcyc, W + 1);
    check({nm, "_quot"}, bus.issuediv_quot, eq);
    check({nm, "_rem"},  bus.issuediv_rem, er);
    check({nm, "_dz"},   bus.issuediv_dz, edz);
    check({nm, "_tag"},  bus.issuediv_rdtag_out, tag);
    tick();
  endtask

  task automatic op8(input bit sgn, input logic [7:0] a, input logic [7:0] b, input logic [TW-1:0] tag,
                     input logic [7:0] eq, input logic [7:0] er, input bit edz, input string nm);
    int cyc;
    tick();
    bus8.issuediv_enable = 1'b1; bus8.issuediv_signed = sgn;
    bus8.issuediv_rsdata = a; bus8.issuediv_rtdata = b; bus8.issuediv_rdtag = tag;
    tick();
    bus8.issuediv_enable = 1'b0;
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus8.issuediv_valid || cyc >= 40) break;
    end
    check({nm, "_lat"},  cyc, W8 + 1);
    check({nm, "_quot"}, bus8.issuediv_quot, eq);
    check({nm, "_rem"},  bus8.issuediv_rem, er);
    check({nm, "_dz"},   bus8.issuediv_dz, edz);
    check({nm, "_tag"},  bus8.issuediv_rdtag_out, tag);
    tick();
  endtask

  initial begin
    logic [63:0] q, r;
    bit dz;
    int vc0;
    bus.issuediv_enable = 0; bus.issuediv_signed = 0; bus.issuediv_rsdata = '0;
    bus.issuediv_rtdata = '0; bus.issuediv_rdtag = '0; bus.issuediv_flush = 0;
    bus8.issuediv_enable = 0; bus8.issuediv_signed = 0; bus8.issuediv_rsdata = '0;
    bus8.issuediv_rtdata = '0; bus8.issuediv_rdtag = '0; bus8.issuediv_flush = 0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", bus.issuediv_busy, 0);
    check("rst_valid", bus.issuediv_valid, 0);
    check("rst_quot", bus.issuediv_quot, 0);
    check("rst_rem", bus.issuediv_rem, 0);
    check("rst_dz", bus.issuediv_dz, 0);
    check("rst_tag", bus.issuediv_rdtag_out, 0);
    check("rst8_busy", bus8.issuediv_busy, 0);
    tick();
    rst_n = 1'b1;
    chk_on = 1'b1;

    // Pin the reference model to hand-computed values.
    ref_div(32, 0, 100, 7, q, r, dz);
    check("model_u_q", q, 14); check("model_u_r", r, 2);
    ref_div(32, 1, 64'hFFFFFFF9, 2, q, r, dz);
    check("model_s_q", q, 64'hFFFFFFFD); check("model_s_r", r, 64'hFFFFFFFF);
    ref_div(8, 1, 8'h80, 8'hFF, q, r, dz);
    check("model_ovf8_q", q, 8'h80); check("model_ovf8_r", r, 0);

    op32(0, 100, 7, 6'h15, 14, 2, 0, "u100_7");
    op32(1, 32'hFFFFFFF9, 2, 6'h01, 32'hFFFFFFFD, 32'hFFFFFFFF, 0, "s_m7_2");
    op32(0, 32'hFFFFFFF9, 2, 6'h02, 32'h7FFFFFFC, 1, 0, "u_m7_2");
    op32(1, 32'h00001234, 0, 6'h03, 32'hFFFFFFFF, 32'h00001234, 1, "s_dz");
    op32(0, 32'h00001234, 0, 6'h04, 32'hFFFFFFFF, 32'h00001234, 1, "u_dz");
    op32(1, 32'hFFFFFF00, 0, 6'h05, 32'hFFFFFFFF, 32'hFFFFFF00, 1, "s_dz_neg");
    op32(1, 32'h80000000, 32'hFFFFFFFF, 6'h06, 32'h80000000, 0, 0, "s_ovf");

    // Enable held through the whole busy window with a changing tag.
    vtags.delete();
    tick();
    for (int j = 0; j <= W + 2; j++) begin
      bus.issuediv_enable = 1'b1; bus.issuediv_signed = 1'b0;
      bus.issuediv_rsdata = 32'(1000 + j); bus.issuediv_rtdata = 7;
      bus.issuediv_rdtag = TW'(j + 1);
      tick();
    end
    bus.issuediv_enable = 1'b0;
    begin
      int cyc, bcyc;
      wait_valid32("spam_b", cyc, bcyc);
      check("spam_b_lat", cyc, W + 1);
      check("spam_b_quot", bus.issuediv_quot, 147);
      check("spam_b_rem", bus.issuediv_rem, 5);
    end
    tick();
    check("spam_nvalid", vtags.size(), 2);
    if (vtags.size() == 2) begin
      check("spam_tag_a", vtags[0], 1);
      check("spam_tag_b", vtags[1], 35);
    end

    // Flush in CALC.
    issue32(0, 12345, 17, 6'h07);
    repeat (9) tick();
    vc0 = vcount;
    bus.issuediv_flush = 1'b1;
    tick();
    bus.issuediv_flush = 1'b0;
    @(negedge clk);
    check("flush_busy", bus.issuediv_busy, 0);
    repeat (40) tick();
    check("flush_novalid", vcount, vc0);

    // Flush in the DONE cycle suppresses the pulse.
    issue32(0, 77, 5, 6'h0C);
    repeat (W) tick();
    bus.issuediv_flush = 1'b1;
    @(negedge clk);
    check("flushdone_valid", bus.issuediv_valid, 0);
    check("flushdone_busy", bus.issuediv_busy, 1);
    tick();
    bus.issuediv_flush = 1'b0;
    @(negedge clk);
    check("flushdone_idle", bus.issuediv_busy, 0);
    check("flushdone_novalid", vcount, vc0);

    // Flush together with enable in IDLE accepts nothing.
    tick();
    bus.issuediv_enable = 1'b1; bus.issuediv_flush = 1'b1; bus.issuediv_rtdata = 3;
    tick();
    bus.issuediv_enable = 1'b0; bus.issuediv_flush = 1'b0;
    @(negedge clk);
    check("flush_en_idle", bus.issuediv_busy, 0);

    // Asynchronous reset mid-divide.
    op32(0, 999, 10, 6'h11, 99, 9, 0, "pre_rst");
    issue32(1, 32'hFFFFFC18, 7, 6'h09);
    repeat (19) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_busy", bus.issuediv_busy, 0);
    check("midrst_valid", bus.issuediv_valid, 0);
    check("midrst_quot", bus.issuediv_quot, 0);
    check("midrst_rem", bus.issuediv_rem, 0);
    check("midrst_dz", bus.issuediv_dz, 0);
    check("midrst_tag", bus.issuediv_rdtag_out, 0);
    tick();
    rst_n = 1'b1;
    op32(0, 50, 5, 6'h0A, 10, 0, 0, "u50_5");

    // Random traffic against the cycle model.
    for (int c = 0; c < 4000; c++) begin
      int k;
      k = int'($urandom % 8);
      bus.issuediv_enable = ($urandom % 4 == 0);
      bus.issuediv_signed = 1'($urandom);
      bus.issuediv_rsdata = $urandom;
      bus.issuediv_rdtag  = TW'($urandom);
      bus.issuediv_flush  = ($urandom % 120 == 0);
      case (k)
        0: bus.issuediv_rtdata = '0;
        1: begin bus.issuediv_rtdata = '1; bus.issuediv_rsdata = 32'h80000000; end
        2: bus.issuediv_rtdata = 32'($urandom % 16 + 1);
        default: bus.issuediv_rtdata = $urandom >> ($urandom % 32);
      endcase
      tick();
    end
    bus.issuediv_enable = 1'b0; bus.issuediv_flush = 1'b0;
    repeat (40) tick();

    // 8-bit instance.
    op8(0, 200, 3, 6'h21, 66, 2, 0, "w8_u200_3");
    op8(1, 8'h80, 8'hFF, 6'h22, 8'h80, 0, 0, "w8_s_ovf");
    op8(1, 8'hF9, 2, 6'h23, 8'hFD, 8'hFF, 0, "w8_s_m7_2");
    op8(0, 8'h5A, 0, 6'h24, 8'hFF, 8'h5A, 1, "w8_dz");
    for (int n = 0; n < 30; n++) begin
      logic [7:0] a, b;
      logic [TW-1:0] tg;
      bit s;
      a = 8'($urandom); b = ($urandom % 6 == 0) ? 8'h00 : 8'($urandom);
      s = 1'($urandom); tg = TW'($urandom);
      ref_div(8, s, 64'(a), 64'(b), q, r, dz);
      op8(s, a, b, tg, q[7:0], r[7:0], dz, "w8_rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end
endmodule
